// File: rtl/req_queue_stage.sv
// rtl/req_queue_stage.sv - per-requester FIFOs feeding a round-robin arbiter, granted words popped onto one registered channel
module req_queue_stage #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          in_valid,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]          in_ready,
    output logic [3:0]          REQ,
    input  logic [3:0]          GNT,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_src,
    output logic                stale_gnt,
    output logic                gnt_err
);
    localparam int N = 4;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [N][DEPTH];
    logic [AW-1:0]     wptr [N];
    logic [AW-1:0]     rptr [N];
    logic [AW:0]       count [N];
    logic [N-1:0]      full, empty, push, pop;
    logic              gnt_onehot, gnt_multi;
    logic [1:0]        pop_src;

    always_comb begin
        full       = '0;
        empty      = '0;
        pop_src    = 2'd0;
        gnt_multi  = (GNT & (GNT - 4'd1)) != 4'd0;
        gnt_onehot = (GNT != 4'd0) && !gnt_multi;
        for (int i = 0; i < N; i++) begin
            full[i]  = (count[i] == FULL_CNT);
            empty[i] = (count[i] == '0);
            if (GNT[i]) pop_src = 2'(i);
        end
        // in_ready is held low for the whole reset window, not just until the first edge
        in_ready = rst ? 4'b0000 : ~full;
        push     = in_valid & in_ready;
        pop      = GNT & ~empty & {N{gnt_onehot}};
        REQ      = ~empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i]) wptr[i] <= wptr[i] + 1'b1;
                if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
                if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
                else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
            end
        end
    end

    // Storage carries no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) mem[i][wptr[i]] <= in_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            stale_gnt <= 1'b0;
            gnt_err   <= 1'b0;
        end else begin
            out_valid <= |pop;
            if (|pop) begin
                out_data <= mem[pop_src][rptr[pop_src]];
                out_src  <= pop_src;
            end
            stale_gnt <= gnt_onehot && |(GNT & empty);
            if (gnt_multi) gnt_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_req_queue_stage.sv
// tb/tb_req_queue_stage.sv - table-driven bench with queue model and output scoreboard for req_queue_stage
module tb_req_queue_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_valid = '0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_ready;
    logic [3:0]  req;
    logic [3:0]  gnt = '0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        stale_gnt;
    logic        gnt_err;

    req_queue_stage #(.DATA_W(8), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .REQ(req), .GNT(gnt), .out_valid(out_valid),
        .out_data(out_data), .out_src(out_src), .stale_gnt(stale_gnt),
        .gnt_err(gnt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_req;
        logic        exp_ovalid;
        logic        exp_stale;
        logic        exp_err;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] mq0[$], mq1[$], mq2[$], mq3[$];
    logic [9:0] sb[$];
    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i, input logic [7:0] b);
        logic [31:0] w;
        w = '0;
        w[i*8 +: 8] = b;
        return w;
    endfunction

    task automatic add(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g,
                       input logic [3:0] rdy, input logic [3:0] rq, input logic ov,
                       input logic st, input logic er);
        vec_t t;
        t.valid = v; t.data = d; t.gnt = g; t.exp_ready = rdy; t.exp_req = rq;
        t.exp_ovalid = ov; t.exp_stale = st; t.exp_err = er;
        vecs.push_back(t);
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return mq0.size();
            1: return mq1.size();
            2: return mq2.size();
            default: return mq3.size();
        endcase
    endfunction

    task automatic qpush(input int i, input logic [7:0] b);
        case (i)
            0: mq0.push_back(b);
            1: mq1.push_back(b);
            2: mq2.push_back(b);
            default: mq3.push_back(b);
        endcase
    endtask

    function automatic logic [7:0] qpop(input int i);
        case (i)
            0: return mq0.pop_front();
            1: return mq1.pop_front();
            2: return mq2.pop_front();
            default: return mq3.pop_front();
        endcase
    endfunction

    // Drives one cycle at the falling edge, advances the reference queues, then checks the output channel.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
        logic [3:0] rdy;
        logic [9:0] e;
        in_valid = v; in_data = d; gnt = g;
        for (int i = 0; i < 4; i++) rdy[i] = qsize(i) < 4;
        if ($countones(g) == 1) begin
            for (int i = 0; i < 4; i++)
                if (g[i] && qsize(i) > 0) sb.push_back({2'(i), qpop(i)});
        end
        for (int i = 0; i < 4; i++)
            if (v[i] && rdy[i]) qpush(i, d[i*8 +: 8]);
        @(posedge clk);
        @(negedge clk);
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_data", int'(out_data), int'(e[7:0]));
                chk("out_src", int'(out_src), int'(e[9:8]));
            end
        end
    endtask

    initial begin
        // reset release and FIFO 2 drain with trailing stale grant
        add(4'b0000, 32'h0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
        add(4'b0000, 32'h0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
        add(4'b0100, lane(2, 8'hA1), 4'b0000, 4'b1111, 4'b0100, 0, 0, 0);
        add(4'b0100, lane(2, 8'hA2), 4'b0000, 4'b1111, 4'b0100, 0, 0, 0);
        add(4'b0000, 32'h0, 4'b0100, 4'b1111, 4'b0100, 1, 0, 0);
        add(4'b0000, 32'h0, 4'b0100, 4'b1111, 4'b0000, 1, 0, 0);
        add(4'b0000, 32'h0, 4'b0100, 4'b1111, 4'b0000, 0, 1, 0);
        add(4'b0000, 32'h0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
        // fill FIFO 0, pop while full with in_valid held, then wrap
        add(4'b0001, lane(0, 8'hB0), 4'b0000, 4'b1111, 4'b0001, 0, 0, 0);
        add(4'b0001, lane(0, 8'hB1), 4'b0000, 4'b1111, 4'b0001, 0, 0, 0);
        add(4'b0001, lane(0, 8'hB2), 4'b0000, 4'b1111, 4'b0001, 0, 0, 0);
        add(4'b0001, lane(0, 8'hB3), 4'b0000, 4'b1110, 4'b0001, 0, 0, 0);
        add(4'b0001, lane(0, 8'hB4), 4'b0001, 4'b1111, 4'b0001, 1, 0, 0);
        add(4'b0001, lane(0, 8'hB4), 4'b0000, 4'b1110, 4'b0001, 0, 0, 0);
        add(4'b0000, 32'h0, 4'b0001, 4'b1111, 4'b0001, 1, 0, 0);
        add(4'b0000, 32'h0, 4'b0001, 4'b1111, 4'b0001, 1, 0, 0);
        add(4'b0000, 32'h0, 4'b0001, 4'b1111, 4'b0001, 1, 0, 0);
        add(4'b0000, 32'h0, 4'b0001, 4'b1111, 4'b0000, 1, 0, 0);
        // simultaneous push and pop on FIFO 1
        add(4'b0010, lane(1, 8'hC1), 4'b0000, 4'b1111, 4'b0010, 0, 0, 0);
        add(4'b0010, lane(1, 8'hC2), 4'b0000, 4'b1111, 4'b0010, 0, 0, 0);
        add(4'b0010, lane(1, 8'h55), 4'b0010, 4'b1111, 4'b0010, 1, 0, 0);
        add(4'b0000, 32'h0, 4'b0010, 4'b1111, 4'b0010, 1, 0, 0);
        add(4'b0000, 32'h0, 4'b0010, 4'b1111, 4'b0000, 1, 0, 0);
        // multi-hot grant leaves contents intact and sets the sticky error
        add(4'b0011, lane(0, 8'hD1) | lane(1, 8'hD2), 4'b0000, 4'b1111, 4'b0011, 0, 0, 0);
        add(4'b0000, 32'h0, 4'b0011, 4'b1111, 4'b0011, 0, 0, 1);
        add(4'b0000, 32'h0, 4'b0000, 4'b1111, 4'b0011, 0, 0, 1);
        add(4'b0000, 32'h0, 4'b0001, 4'b1111, 4'b0010, 1, 0, 1);
        add(4'b0000, 32'h0, 4'b0010, 4'b1111, 4'b0000, 1, 0, 1);
        // load FIFO 3 and start draining it
        add(4'b1000, lane(3, 8'hE1), 4'b0000, 4'b1111, 4'b1000, 0, 0, 1);
        add(4'b1000, lane(3, 8'hE2), 4'b0000, 4'b1111, 4'b1000, 0, 0, 1);
        add(4'b1000, lane(3, 8'hE3), 4'b0000, 4'b1111, 4'b1000, 0, 0, 1);
        add(4'b0000, 32'h0, 4'b1000, 4'b1111, 4'b1000, 1, 0, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_req", int'(req), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_src", int'(out_src), 0);
        chk("rst_stale", int'(stale_gnt), 0);
        chk("rst_err", int'(gnt_err), 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            step(vecs[k].valid, vecs[k].data, vecs[k].gnt);
            chk($sformatf("v%0d_in_ready", k), int'(in_ready), int'(vecs[k].exp_ready));
            chk($sformatf("v%0d_req", k), int'(req), int'(vecs[k].exp_req));
            chk($sformatf("v%0d_out_valid", k), int'(out_valid), int'(vecs[k].exp_ovalid));
            chk($sformatf("v%0d_stale", k), int'(stale_gnt), int'(vecs[k].exp_stale));
            chk($sformatf("v%0d_gnt_err", k), int'(gnt_err), int'(vecs[k].exp_err));
        end

        // asynchronous reset mid-drain while the grant is still held
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_req", int'(req), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_err", int'(gnt_err), 0);
        mq0.delete(); mq1.delete(); mq2.delete(); mq3.delete();
        sb.delete();
        gnt = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(4'b0000, 32'h0, 4'b0000);
        chk("post_in_ready", int'(in_ready), 15);
        chk("post_req", int'(req), 0);
        chk("post_out_valid", int'(out_valid), 0);
        step(4'b0000, 32'h0, 4'b1000);
        chk("post_empty_stale", int'(stale_gnt), 1);
        chk("post_empty_out_valid", int'(out_valid), 0);
        step(4'b0000, 32'h0, 4'b0000);
        chk("post_stale_clears", int'(stale_gnt), 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
